// File: rtl/alu.sv
// alu: 16-bit WISC execute ALU with registered {Z,V,N} flags; opcode 7 packed nibble add when ALU_PADDSB_EN is defined
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ALU_In1,
  input  logic [15:0] ALU_In2,
  input  logic [2:0]  Opcode,
  output logic [15:0] ALU_Out,
  output logic        Error,
  output logic [2:0]  flags
);
  logic [15:0] sum, diff, ror_res, pad_res;
  logic [31:0] ror_wide;
  logic [3:0]  sh;
  logic        add_pos_ovf, add_neg_ovf, sub_pos_sat, sub_neg_sat, add_sat, sub_sat, pad_err;
  logic [2:0]  flags_q, flags_d;
  assign sum         = ALU_In1 + ALU_In2;
  assign diff        = ALU_In1 - ALU_In2;
  assign sh          = ALU_In2[3:0];
  assign add_pos_ovf = ~ALU_In1[15] & ~ALU_In2[15] & sum[15];
  assign add_neg_ovf = ALU_In1[15] & ALU_In2[15] & ~sum[15];
  assign add_sat     = add_pos_ovf | add_neg_ovf;
  assign sub_neg_sat = ALU_In1[15] & ~ALU_In2[15] & (|ALU_In2) & ~diff[15];
  assign sub_pos_sat = ~ALU_In1[15] & (|ALU_In1) & ALU_In2[15] & diff[15];
  assign sub_sat     = sub_pos_sat | sub_neg_sat;
  assign ror_wide    = {ALU_In1, ALU_In1} >> sh;
  assign ror_res     = ror_wide[15:0];
`ifdef ALU_PADDSB_EN
  logic [3:0] nib_ovf;
  for (genvar n = 0; n < 4; n++) begin : g_nib
    logic [3:0] a, b, s;
    assign a          = ALU_In1[4*n +: 4];
    assign b          = ALU_In2[4*n +: 4];
    assign s          = a + b;
    assign nib_ovf[n] = (a[3] == b[3]) && (s[3] != a[3]);
    assign pad_res[4*n +: 4] = nib_ovf[n] ? (a[3] ? 4'h8 : 4'h7) : s;
  end
  assign pad_err = |nib_ovf;
`else
  assign pad_res = 16'h0000;
  assign pad_err = 1'b1;
`endif
  // result and error select by opcode
  always_comb begin
    ALU_Out = 16'h0000;
    Error   = 1'b0;
    case (Opcode)
      3'd0: begin
        ALU_Out = add_pos_ovf ? 16'h7FFF : add_neg_ovf ? 16'h8000 : sum;
        Error   = add_sat;
      end
      3'd1: begin
        ALU_Out = sub_pos_sat ? 16'h7FFF : sub_neg_sat ? 16'h8000 : diff;
        Error   = sub_sat;
      end
      3'd2, 3'd3: ALU_Out = ALU_In1 ^ ALU_In2;
      3'd4: ALU_Out = ALU_In1 << sh;
      3'd5: ALU_Out = $signed(ALU_In1) >>> sh;
      3'd6: ALU_Out = ror_res;
      default: begin
        ALU_Out = pad_res;
        Error   = pad_err;
      end
    endcase
  end
  // next flags: arithmetic writes all three, logic/shift writes Z only, packed add holds
  always_comb begin
    flags_d = flags_q;
    if (Opcode == 3'd0 || Opcode == 3'd1)
      flags_d = {ALU_Out == 16'h0000, Opcode == 3'd0 ? add_sat : sub_sat, ALU_Out[15]};
    else if (Opcode != 3'd7)
      flags_d[2] = ALU_Out == 16'h0000;
  end
  // flag register, reset overrides any update
  always_ff @(posedge clk) flags_q <= rst ? 3'b000 : flags_d;
  assign flags = flags_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector scoreboard bench for alu
module tb_alu;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic [2:0]  op = '0;
  logic [15:0] out;
  logic        err;
  logic [2:0]  flags;
  int checks = 0, fails = 0;
  typedef struct {
    string       nm;
    logic [15:0] out;
    logic        err;
    logic [2:0]  flg;
  } exp_t;
  exp_t cq[$];
  exp_t fq[$];
  exp_t pend;
  logic have_pend = 1'b0;
`ifdef ALU_PADDSB_EN
  localparam logic [15:0] P7_OUT = 16'h2345;
  localparam logic        P7_ERR = 1'b0;
`else
  localparam logic [15:0] P7_OUT = 16'h0000;
  localparam logic        P7_ERR = 1'b1;
`endif
  alu dut (
    .clk(clk), .rst(rst), .ALU_In1(a), .ALU_In2(b), .Opcode(op),
    .ALU_Out(out), .Error(err), .flags(flags)
  );
  always #5 clk = ~clk;
  task automatic issue(input string nm, input logic r, input logic [2:0] o, input logic [15:0] x,
                       input logic [15:0] y, input logic [15:0] eo, input logic ee, input logic [2:0] ef);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; op = o; a = x; b = y;
    e.nm = nm; e.out = eo; e.err = ee; e.flg = ef;
    cq.push_back(e);
    fq.push_back(e);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (have_pend) begin
      checks++;
      if (flags !== pend.flg) begin
        fails++;
        $display("FAIL %s flags: got %b expected %b", pend.nm, flags, pend.flg);
      end
    end
    if (cq.size() > 0) begin
      e = cq.pop_front();
      checks++;
      if (out !== e.out || err !== e.err) begin
        fails++;
        $display("FAIL %s result: got %h/%b expected %h/%b", e.nm, out, err, e.out, e.err);
      end
    end
    have_pend = fq.size() > 0;
    if (have_pend) pend = fq.pop_front();
  end
  initial begin
    int waited;
    issue("reset",     1, 3'd0, 16'h0000, 16'h0000, 16'h0000, 0, 3'b000);
    issue("add_edge",  0, 3'd0, 16'h8000, 16'h8001, 16'h8000, 1, 3'b011);
    issue("add_povf",  0, 3'd0, 16'h7000, 16'h7000, 16'h7FFF, 1, 3'b010);
    issue("add_plain", 0, 3'd0, 16'h1234, 16'h1111, 16'h2345, 0, 3'b000);
    issue("add_zero",  0, 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 0, 3'b100);
    issue("add_neg",   0, 3'd0, 16'hFFFE, 16'hFFFF, 16'hFFFD, 0, 3'b001);
    issue("add_mixed", 0, 3'd0, 16'h8000, 16'h7FFF, 16'hFFFF, 0, 3'b001);
    issue("sub_edge",  0, 3'd1, 16'h80C2, 16'h7CFF, 16'h8000, 1, 3'b011);
    issue("sub_povf",  0, 3'd1, 16'h7FF0, 16'hFFF0, 16'h7FFF, 1, 3'b010);
    issue("sub_zero",  0, 3'd1, 16'h1234, 16'h1234, 16'h0000, 0, 3'b100);
    issue("sub_neg",   0, 3'd1, 16'h0005, 16'h0007, 16'hFFFE, 0, 3'b001);
    issue("xor_zero",  0, 3'd2, 16'hBEEF, 16'hBEEF, 16'h0000, 0, 3'b101);
    issue("xor_op3",   0, 3'd3, 16'hF0F0, 16'h0FF0, 16'hFF00, 0, 3'b001);
    issue("sll",       0, 3'd4, 16'h8001, 16'h0004, 16'h0010, 0, 3'b001);
    issue("sra",       0, 3'd5, 16'h8001, 16'h0004, 16'hF800, 0, 3'b001);
    issue("ror",       0, 3'd6, 16'h8001, 16'h0004, 16'h1800, 0, 3'b001);
    issue("ror_zero",  0, 3'd6, 16'h1234, 16'h0000, 16'h1234, 0, 3'b001);
    issue("sll_out",   0, 3'd4, 16'h8000, 16'h0001, 16'h0000, 0, 3'b101);
    issue("sra_amt",   0, 3'd5, 16'h4000, 16'h00F2, 16'h1000, 0, 3'b001);
    issue("op7",       0, 3'd7, 16'h1234, 16'h1111, P7_OUT, P7_ERR, 3'b001);
    issue("add_povf2", 0, 3'd0, 16'h4000, 16'h4000, 16'h7FFF, 1, 3'b010);
    issue("rst_win",   1, 3'd0, 16'h0000, 16'h0000, 16'h0000, 0, 3'b000);
    issue("post_rst",  0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 0, 3'b100);
    issue("xor_nz",    0, 3'd2, 16'h0001, 16'h0000, 16'h0001, 0, 3'b000);
    @(posedge clk);
    #1;
    op = 3'd2; a = '0; b = '0;
    waited = 0;
    while ((cq.size() > 0 || fq.size() > 0 || have_pend) && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    checks++;
    if (waited >= 20) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", cq.size() + fq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/alu.md
Name: alu

Overview:
- 16-bit combinational ALU for the execute stage of the WISC datapath, with a registered 3-bit condition-flag register (Z, V, N).
- Result and Error are combinational from the operands and opcode.
- The flags output is the registered flag state, updated on the clock edge from the current operation; the branch unit consumes it.

Parameters:
- none (fixed 16-bit datapath, 3-bit opcode)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- ALU_In1  input  16  operand A, two's complement
- ALU_In2  input  16  operand B, two's complement; bits [3:0] are the shift/rotate amount for opcodes 4-6
- Opcode  input  3  operation select
- ALU_Out  output  16  combinational result
- Error  output  1  combinational; 1 when the current op saturated or the opcode is unsupported
- flags  output  3  registered {Z, V, N}: flags[2]=Z, flags[1]=V, flags[0]=N

Behaviour:
- Opcode 0, ADD, 16-bit saturating:
  - pos+pos with sign-bit result -> 0x7FFF.
  - neg+neg with non-negative raw result -> 0x8000.
  - otherwise wrapped A+B.
  - Error = 1 when saturated.
- Opcode 1, SUB (A-B), saturating:
  - A<0, B>0, raw result >=0 -> 0x8000.
  - A>0, B<0, raw result <0 -> 0x7FFF.
  - otherwise A-B.
  - Error = 1 when saturated.
- Opcode 2, XOR: A ^ B.
- Opcode 3, XOR: A ^ B (aliases opcode 2).
- Opcode 4, SLL: A << In2[3:0], zero fill.
- Opcode 5, SRA: A >>> In2[3:0], sign fill.
- Opcode 6, ROR: A rotated right by In2[3:0]; an amount of 0 passes A through unchanged.
- Opcode 7, PADDSB: the ALU_PADDSB_EN feature below.
- Flag update on the rising clk edge (when rst=0):
  - ADD/SUB: Z <= (ALU_Out==0), V <= saturated, N <= ALU_Out[15].
  - XOR/SLL/SRA/ROR: Z <= (ALU_Out==0); V and N hold.
  - PADDSB: all flags hold.
- Flag semantics: N and Z are evaluated on the saturated result, never the raw wrapped result.
- Reset: rst=1 at a clock edge -> flags <= 3'b000.
  - Reset wins over a simultaneous flag update.
  - ALU_Out and Error are combinational and unaffected by reset.
- Latency: ALU_Out/Error are valid in the same cycle as the inputs; flags reflect the op one clock later.
- No X propagation: every opcode value produces a defined ALU_Out and Error.

Optional Feature:
- Macro: ALU_PADDSB_EN.
- Defined: opcode 7 = four independent 4-bit saturating adds on nibbles [3:0], [7:4], [11:8], [15:12].
  - Each nibble saturates to 0x7 or 0x8 on overflow.
  - Error = 1 if any nibble saturated.
- Not defined: opcode 7 gives ALU_Out = 0x0000 and Error = 1; flags hold.

Test Plan:
- ADD random: 131071 random A/B pairs with Opcode=0 -> ALU_Out equals the saturating sum each time; after each clock, Z set when the result is 0 and N set when ALU_Out[15]=1.
- ADD edge: A=0x8000, B=0x8001 -> ALU_Out=0x8000, Error=1; after the clock, flags=3'b011.
- ADD positive overflow: A=0x7000, B=0x7000 -> ALU_Out=0x7FFF, Error=1; after the clock, flags=3'b010.
- SUB: 131071 random pairs -> ALU_Out equals the saturating difference.
- SUB edge: A=0x80C2, B=0x7CFF -> 0x8000, Error=1.
- SUB zero: A=B=0x1234 -> 0x0000; after the clock, flags[2]=1.
- XOR: random pairs with Opcode=2 and Opcode=3 -> ALU_Out = A^B.
- XOR zero: A=B=0xBEEF -> 0x0000; after the clock, Z=1 and V/N unchanged.
- Shifts, A=0x8001, In2=0x0004:
  - SLL -> 0x0010.
  - SRA -> 0xF800.
  - ROR -> 0x1800.
- Reset: set flags via ADD overflow, then assert rst for one clock while Opcode=0 with A=B=0 -> flags=3'b000. Next clock with rst=0 -> flags=3'b100.
